booth_product_accumulator: RTL and testbench

//   Downstream stage of the combinational Booth multiplier. Consumes a stream of signed

---
 rtl/booth_product_accumulator.sv | 113 +++++++++++
 tb/tb_booth_product_accumulator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_product_accumulator.sv
// Sums frames of up to N_TERMS signed Booth products and presents each total on a valid/ready output.
// Optional macro SATURATE_EN: clamp the accumulator on signed overflow instead of wrapping.
module booth_product_accumulator #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [PROD_W-1:0]         in_prod,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [ACC_W-1:0]          out_sum,
    output logic [$clog2(N_TERMS+1)-1:0]     out_count,
    output logic                             out_ovf
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ovf;
    logic                    r_outValid;
    logic signed [ACC_W-1:0] r_outSum;
    logic [CNT_W-1:0]        r_outCount;
    logic                    r_outOvf;

    logic signed [ACC_W-1:0] w_prodExt;
    logic signed [ACC_W-1:0] w_rawSum;
    logic signed [ACC_W-1:0] w_nextAcc;
    logic [CNT_W-1:0]        w_nextCnt;
    logic                    w_addOvf;
    logic                    w_nextOvf;
    logic                    w_accept;
    logic                    w_frameEnd;

    assign in_ready  = rst_n && (r_state == ACCUM);
    assign w_accept  = in_valid && in_ready;

    // Overflow: both addends share a sign and the sum's sign differs from it.
    assign w_prodExt = ACC_W'(in_prod);
    assign w_rawSum  = r_acc + w_prodExt;
    assign w_addOvf  = (r_acc[ACC_W-1] == w_prodExt[ACC_W-1]) &&
                       (w_rawSum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_nextOvf = r_ovf | w_addOvf;
    assign w_nextCnt = r_cnt + CNT_W'(1);
    assign w_frameEnd = (r_cnt == CNT_W'(N_TERMS - 1)) || in_last;

`ifdef SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    assign w_nextAcc = w_addOvf ? (r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_rawSum;
`else
    assign w_nextAcc = w_rawSum;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ACCUM;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_outValid <= 1'b0;
            r_outSum   <= '0;
            r_outCount <= '0;
            r_outOvf   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_nextAcc;
                        r_cnt <= w_nextCnt;
                        r_ovf <= w_nextOvf;
                        if (w_frameEnd) begin
                            r_state    <= HOLD;
                            r_outValid <= 1'b1;
                            r_outSum   <= w_nextAcc;
                            r_outCount <= w_nextCnt;
                            r_outOvf   <= w_nextOvf;
                        end
                    end
                end
                HOLD: begin
                    // Partial state is cleared only once the consumer has taken the frame.
                    if (out_ready) begin
                        r_state    <= ACCUM;
                        r_outValid <= 1'b0;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_ovf      <= 1'b0;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign out_sum   = r_outSum;
    assign out_count = r_outCount;
    assign out_ovf   = r_outOvf;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Scoreboard bench for booth_product_accumulator: default instance plus ACC_W=8 and N_TERMS=1 instances.
// Expected overflow behaviour follows the SATURATE_EN macro.
module tb_booth_product_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [7:0]  inProd;
    logic        inLast;
    logic        outValid;
    logic        outReady;
    logic [15:0] outSum;
    logic [2:0]  outCount;
    logic        outOvf;

    logic        sValid;
    logic [7:0]  sProd;
    logic        sLast;
    logic        sOutReady;
    logic        w8InReady;
    logic        w8OutValid;
    logic [7:0]  w8OutSum;
    logic [2:0]  w8OutCount;
    logic        w8OutOvf;
    logic        n1InReady;
    logic        n1OutValid;
    logic [7:0]  n1OutSum;
    logic [0:0]  n1OutCount;
    logic        n1OutOvf;

    booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .N_TERMS(4)) dut (
        .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
        .in_prod(inProd), .in_last(inLast), .out_valid(outValid), .out_ready(outReady),
        .out_sum(outSum), .out_count(outCount), .out_ovf(outOvf)
    );

    booth_product_accumulator #(.PROD_W(8), .ACC_W(8), .N_TERMS(4)) dutNarrow (
        .clk(clk), .rst_n(rstN), .in_valid(sValid), .in_ready(w8InReady),
        .in_prod(sProd), .in_last(sLast), .out_valid(w8OutValid), .out_ready(sOutReady),
        .out_sum(w8OutSum), .out_count(w8OutCount), .out_ovf(w8OutOvf)
    );

    booth_product_accumulator #(.PROD_W(8), .ACC_W(8), .N_TERMS(1)) dutSingle (
        .clk(clk), .rst_n(rstN), .in_valid(sValid), .in_ready(n1InReady),
        .in_prod(sProd), .in_last(sLast), .out_valid(n1OutValid), .out_ready(sOutReady),
        .out_sum(n1OutSum), .out_count(n1OutCount), .out_ovf(n1OutOvf)
    );

    typedef struct packed {
        logic [15:0] sum;
        logic [2:0]  count;
        logic        ovf;
    } frame_t;

    frame_t expQ[$];
    frame_t expFrame;
    int     checkCount = 0;
    int     failCount  = 0;
    int     modelAcc   = 0;
    int     modelCnt   = 0;
    bit     modelOvf   = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference accumulator works on plain integers with range checks, 16-bit result.
    function automatic void modelAccept(input int prod, input bit last);
        int sum;
        frame_t f;
        sum = modelAcc + prod;
        if (sum > 32767 || sum < -32768) begin
            modelOvf = 1'b1;
`ifdef SATURATE_EN
            sum = (sum > 0) ? 32767 : -32768;
`else
            if (sum > 32767) sum -= 65536;
            else sum += 65536;
`endif
        end
        modelAcc = sum;
        modelCnt++;
        if (modelCnt == 4 || last) begin
            f.sum   = modelAcc[15:0];
            f.count = modelCnt[2:0];
            f.ovf   = modelOvf;
            expQ.push_back(f);
            modelAcc = 0;
            modelCnt = 0;
            modelOvf = 1'b0;
        end
    endfunction

    // Holds one product on the input until it is accepted; waits counts stalled cycles.
    task automatic applyStimulus(input logic [7:0] prod, input logic last, output int waits);
        bit accepted;
        accepted = 1'b0;
        waits    = 0;
        inValid  = 1'b1;
        inProd   = prod;
        inLast   = last;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            if (inReady) accepted = 1'b1;
            else waits++;
        end
        if (accepted) begin
            @(posedge clk);
            #1;
            modelAccept($signed(prod), last);
        end else begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
        end
    endtask

    task automatic idleCycles(input int n);
        inValid = 1'b0;
        inLast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstN && outValid) checkOutput("inReadyInHold", {31'd0, inReady}, 32'd0);
        if (rstN && outValid && outReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedFrame", 32'd1, 32'd0);
            end else begin
                expFrame = expQ.pop_front();
                checkOutput("frameSum", {16'd0, outSum}, {16'd0, expFrame.sum});
                checkOutput("frameCount", {29'd0, outCount}, {29'd0, expFrame.count});
                checkOutput("frameOvf", {31'd0, outOvf}, {31'd0, expFrame.ovf});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waits;
        int opA[8] = '{7, -8, -8, 3, 0, -1, 6, -3};
        int opB[8] = '{7, -8, 7, -5, 5, -1, -7, 4};
        int prodVal;

        rstN = 1'b0; inValid = 1'b0; inProd = 8'd0; inLast = 1'b0; outReady = 1'b1;
        sValid = 1'b0; sProd = 8'd0; sLast = 1'b0; sOutReady = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("resetInReady", {31'd0, inReady}, 32'd0);
        checkOutput("resetOutValid", {31'd0, outValid}, 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("idleOutSum", {16'd0, outSum}, 32'd0);
        checkOutput("idleOutCount", {29'd0, outCount}, 32'd0);
        checkOutput("idleOutOvf", {31'd0, outOvf}, 32'd0);
        checkOutput("idleInReady", {31'd0, inReady}, 32'd1);
        @(posedge clk); #1;

        // Full frame of four terms, total -7
        applyStimulus(8'd21, 1'b0, waits);
        applyStimulus(8'(-21), 1'b0, waits);
        applyStimulus(8'd35, 1'b0, waits);
        applyStimulus(8'(-42), 1'b0, waits);
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("latencyOutValid", {31'd0, outValid}, 32'd1);
        checkOutput("fullFrameSum", {16'd0, outSum}, 32'h0000FFF9);
        @(posedge clk); #1;
        idleCycles(2);

        // Early close with in_last
        applyStimulus(8'(-35), 1'b0, waits);
        applyStimulus(8'd30, 1'b1, waits);
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("earlyOutValid", {31'd0, outValid}, 32'd1);
        checkOutput("earlyOutCount", {29'd0, outCount}, 32'd2);
        @(posedge clk); #1;
        idleCycles(2);

        // Consumer stalls; a pending product must not be taken during HOLD
        outReady = 1'b0;
        applyStimulus(8'd5, 1'b0, waits);
        applyStimulus(8'd6, 1'b1, waits);
        inProd = 8'd42;
        inLast = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stallOutValid", {31'd0, outValid}, 32'd1);
            checkOutput("stallOutSum", {16'd0, outSum}, 32'd11);
            checkOutput("stallOutCount", {29'd0, outCount}, 32'd2);
            @(posedge clk); #1;
        end
        outReady = 1'b1;
        applyStimulus(8'd42, 1'b0, waits);
        checkOutput("bubbleAfterStall", waits, 32'd1);
        applyStimulus(8'd8, 1'b1, waits);
        idleCycles(3);

        // Reset in mid-frame discards partial data
        applyStimulus(8'd7, 1'b0, waits);
        applyStimulus(8'd9, 1'b0, waits);
        inValid = 1'b0;
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midResetInReady", {31'd0, inReady}, 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        modelAcc = 0;
        modelCnt = 0;
        modelOvf = 1'b0;
        @(negedge clk);
        checkOutput("postResetOutValid", {31'd0, outValid}, 32'd0);
        checkOutput("postResetOutCount", {29'd0, outCount}, 32'd0);
        @(posedge clk); #1;
        applyStimulus(8'd1, 1'b0, waits);
        applyStimulus(8'd2, 1'b0, waits);
        applyStimulus(8'd3, 1'b0, waits);
        applyStimulus(8'd4, 1'b0, waits);
        idleCycles(3);

        // Back-to-back frames over Booth 4x4 operand pairs: one bubble per frame
        for (int i = 0; i < 8; i++) begin
            prodVal = opA[i] * opB[i];
            applyStimulus(prodVal[7:0], 1'b0, waits);
            checkOutput($sformatf("bubble%0d", i), waits, (i == 4) ? 32'd1 : 32'd0);
        end
        idleCycles(3);

        // Narrow accumulator overflow and single-term frames
        sValid = 1'b1; sProd = 8'd100; sLast = 1'b0;
        @(posedge clk); #1;
        sLast = 1'b1;
        @(negedge clk);
        checkOutput("singleOutValid", {31'd0, n1OutValid}, 32'd1);
        checkOutput("singleInReady", {31'd0, n1InReady}, 32'd0);
        checkOutput("singleOutCount", {31'd0, n1OutCount}, 32'd1);
        checkOutput("singleOutSum", {24'd0, n1OutSum}, 32'h64);
        checkOutput("narrowInReady", {31'd0, w8InReady}, 32'd1);
        @(posedge clk); #1;
        sValid = 1'b0; sLast = 1'b0;
        @(negedge clk);
        checkOutput("narrowOutValid", {31'd0, w8OutValid}, 32'd1);
`ifdef SATURATE_EN
        checkOutput("narrowOutSum", {24'd0, w8OutSum}, 32'h7F);
`else
        checkOutput("narrowOutSum", {24'd0, w8OutSum}, 32'hC8);
`endif
        checkOutput("narrowOutOvf", {31'd0, w8OutOvf}, 32'd1);
        checkOutput("narrowOutCount", {29'd0, w8OutCount}, 32'd2);
        checkOutput("singleHeldSum", {24'd0, n1OutSum}, 32'h64);
        checkOutput("singleHeldOvf", {31'd0, n1OutOvf}, 32'd0);
        @(posedge clk); #1;
        sOutReady = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("narrowReleased", {31'd0, w8OutValid}, 32'd0);
        checkOutput("singleReleased", {31'd0, n1OutValid}, 32'd0);
        @(posedge clk); #1;

        for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clk);
        #1;
        checkOutput("scoreboardDrained", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
